// File: rtl/cla_add_arbiter_pkg.sv
// Shared types for the CLA add arbiter: FSM state encoding and ID-width helper.
package cla_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester ID width; a 2-requester arbiter still needs a 1-bit ID.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_add_arbiter_if.sv
// Request/response bundle between ALU-side requesters and the shared adder arbiter.
interface cla_add_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int IDW = cla_arb_pkg::clog2_min1(NREQ);

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][WIDTH-1:0]  req_a;
  logic [NREQ-1:0][WIDTH-1:0]  req_b;
  logic [NREQ-1:0]             req_cin;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [IDW-1:0]              rsp_id;
  logic [WIDTH:0]              rsp_result;
  logic                        rsp_overflow;
  logic                        busy;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, busy
  );
endinterface

// File: rtl/cla_add_arbiter_cla.sv
// Carry-lookahead adder: 4-bit lookahead groups rippling group carries.
module CLA_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   result_o,
  output logic             overflow_o
);
  localparam int NG = (WIDTH + 3) / 4;
  localparam int WP = NG * 4;

  logic [WP-1:0] a_p, b_p, g, p, s;
  logic [WP:0]   c;

  // Zero padding keeps c[WIDTH] equal to the real carry-out.
  assign a_p  = WP'(a_i);
  assign b_p  = WP'(b_i);
  assign g    = a_p & b_p;
  assign p    = a_p ^ b_p;
  assign c[0] = cin_i;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign s          = p ^ c[WP-1:0];
  assign result_o   = {c[WIDTH], s[WIDTH-1:0]};
  assign overflow_o = ~(a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (a_i[WIDTH-1] ^ s[WIDTH-1]);
endmodule

// File: rtl/cla_add_arbiter_rr_pick.sv
// Round-robin picker: first set request bit above last_i, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] grant_oh_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_o
);
  always_comb begin
    int idx;
    idx         = 0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = |req_i;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NREQ;
      if (req_i[idx]) grant_idx_o = IDW'(idx);
    end
    grant_oh_o[grant_idx_o] = any_o;
  end
endmodule

// File: rtl/cla_add_arbiter.sv
// Round-robin sequencer sharing one CLA_adder among NREQ requesters:
// grant -> operand capture (IDLE), add (EXEC), hold response (RESP).
module cla_add_arbiter
  import cla_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_add_arbiter_if.slave  bus
);
  localparam int IDW = clog2_min1(NREQ);

  state_e           state_q;
  logic [IDW-1:0]   last_q, id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic [WIDTH:0]   res_q;
  logic             ovf_q, rsp_valid_q, busy_q;

  logic [NREQ-1:0]  grant_oh;
  logic [IDW-1:0]   grant_idx;
  logic             any_req;
  logic [WIDTH:0]   sum_w;
  logic             ovf_w;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i       (bus.req_valid),
    .last_i      (last_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  CLA_adder #(.WIDTH(WIDTH)) u_add (
    .a_i        (a_q),
    .b_i        (b_q),
    .cin_i      (cin_q),
    .result_o   (sum_w),
    .overflow_o (ovf_w)
  );

  // Grant is combinational so the handshake completes in the IDLE cycle;
  // gated by rst_n so it also drops the instant reset asserts.
  assign bus.req_ready    = (rst_n && state_q == IDLE) ? grant_oh : '0;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.busy         = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          a_q     <= bus.req_a[grant_idx];
          b_q     <= bus.req_b[grant_idx];
          cin_q   <= bus.req_cin[grant_idx];
          id_q    <= grant_idx;
          last_q  <= grant_idx;
          busy_q  <= 1'b1;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q       <= sum_w;
          ovf_q       <= ovf_w;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/cla_add_arbiter.md
Name: cla_add_arbiter

Overview:
Shares a single CLA_adder instance among NREQ requesters.
- Round-robin arbitration selects one requester at a time.
- Operands are captured into registers and the add runs on the shared adder.
- The registered result is returned on one valid/ready response channel, tagged with the requester ID.
- Sits between the ALU-side requesters and the adder datapath; it is the only sequencer of the adder.

Parameters:
- WIDTH, 32, operand width in bits; passed to CLA_adder.
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), derived localparam; width of the requester ID.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; at most one bit high.
- req_a  in  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing as req_a.
- req_cin  in  NREQ  per-requester carry-in.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_result  out  WIDTH+1  {carry_out, sum}.
- rsp_overflow  out  1  signed overflow flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE, last_grant=NREQ-1, so requester 0 has first priority.
- Operand registers, rsp_result, rsp_id and rsp_overflow are cleared to 0.
- rsp_valid=0, req_ready=0, busy=0, all immediately on assertion.

FSM states: IDLE, EXEC, RESP.

IDLE:
- If no req_valid bit is set, stay in IDLE and hold all req_ready bits at 0.
- Otherwise, the grant g is the first set req_valid bit scanning upward from last_grant+1, modulo NREQ.
- req_ready[g]=1 combinationally in the same cycle.
- On that clock edge: capture req_a[g], req_b[g], req_cin[g] and id g; set last_grant=g; go to EXEC.
- A request is accepted only on the cycle where req_valid[i] && req_ready[i].

EXEC:
- The adder is driven from the operand registers.
- At the edge, register rsp_result = A + B + cin as WIDTH+1 bits.
- rsp_overflow = ~(A[W-1]^B[W-1]) & (A[W-1]^sum[W-1]).
- Go to RESP. All req_ready bits are 0.

RESP:
- rsp_valid=1; rsp_id, rsp_result and rsp_overflow are held stable.
- On rsp_valid && rsp_ready, go to IDLE. There is no new grant in this cycle.

Latency and throughput:
- Handshake at edge N puts rsp_valid high during cycle N+2.
- Peak throughput is one operation per 3 cycles with rsp_ready held high.

Boundary conditions:
- Single active requester: it is granted every round; no starvation or skip penalty.
- last_grant=NREQ-1: the scan wraps to requester 0.
- Any requester with req_valid held is granted within NREQ operations.
- Requesters must not drop req_valid before the handshake (protocol rule). If one does, the arbiter simply re-scans; no assertion fires.
- req_valid must not depend combinationally on req_ready.
- Reset during EXEC or RESP: the operation is discarded and the response is never issued.
- Result width: the carry-out is always present in bit WIDTH; the sum wraps modulo 2^WIDTH.

Decomposition:
Package cla_arb_pkg contains:
- State encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Function clog2_min1 for IDW, so that NREQ=2 gives IDW=1.

Sub-modules:
- rr_pick: purely combinational. Takes req vector and last_grant; returns grant_onehot, grant_idx and any_req.
- The CLA_adder (WIDTH) is instantiated as the shared datapath. Its Result maps to rsp_result and its Overflow to rsp_overflow, through the EXEC register stage.

Test Plan:
1. Single add, WIDTH=32: req0 A=0x00000005, B=0x00000003, cin=1; rsp_ready=1 -> req_ready[0] pulses once; two cycles later rsp_valid=1, rsp_id=0, rsp_result=0x0_00000009, rsp_overflow=0.
2. Carry and overflow:
   - A=0x7FFFFFFF, B=0x00000001, cin=0 -> result 0x0_80000000, overflow=1.
   - A=0xFFFFFFFF, B=0x00000001, cin=0 -> result 0x1_00000000, overflow=0.
   - A=0x80000000, B=0x80000000 -> result 0x1_00000000, overflow=1.
3. Round robin: all 4 req_valid held high after reset for 8 operations -> rsp_id sequence 0,1,2,3,0,1,2,3, each response 3 cycles apart.
4. Sparse wrap: after req3 is served, only req1 and req2 are valid -> grant 1, then 2, then 1.
5. Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid stays 1, rsp_id/result stable, all req_ready=0, busy=1; release -> IDLE next cycle, next grant on the following cycle.
6. Reset mid-op: assert rst_n=0 during EXEC -> rsp_valid and busy drop immediately, no response issued; after release with req0 and req2 valid, req0 is granted first.
